score_uart_tx: RTL and testbench

SCORE_UART_TX -- requirements
Module: score_uart_tx

---
 rtl/score_uart_pkg.sv | 20 ++
 rtl/uart_tx_byte.sv | 118 +++++++++++
 rtl/score_uart_tx.sv | 96 +++++++++
 tb/tb_score_uart_tx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/score_uart_pkg.sv
// Shared types and defaults for the score UART transmitter.
// The PARITY state exists only when SCORE_UART_TX_PARITY_EN is defined.
package score_uart_pkg;

  localparam int         FRAME_BYTES          = 3;
  localparam logic [7:0] DEFAULT_FRAME_HDR    = 8'h53;
  localparam int         DEFAULT_CLKS_PER_BIT = 217;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SCORE_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP,
    DONE
  } t_State;

endpackage

// File: rtl/uart_tx_byte.sv
// One-byte UART serializer: start, 8 data bits LSB first, optional even parity
// (SCORE_UART_TX_PARITY_EN), stop. A new byte can be taken in the last stop cycle.
module uart_tx_byte
  import score_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [7:0] i_Byte,
  input  logic       i_Valid,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_Tx,
  output logic       o_Active
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  t_State           r_State;
  logic [CNT_W-1:0] r_Cnt;
  logic [2:0]       r_BitIdx;
  logic [7:0]       r_Data;
  logic             r_Tx;
  logic             w_BitEnd;
  logic             w_Done;

  assign w_BitEnd = (r_Cnt == LAST_CNT);
  assign w_Done   = (r_State == STOP) && w_BitEnd;
  assign o_Done   = w_Done;
  // Dropping busy in the final stop cycle lets bytes run back-to-back.
  assign o_Busy   = (r_State != IDLE) && !w_Done;
  assign o_Active = (r_State != IDLE);
  assign o_Tx     = r_Tx;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_State  <= IDLE;
      r_Cnt    <= '0;
      r_BitIdx <= '0;
      r_Data   <= '0;
      r_Tx     <= 1'b1;
    end else begin
      case (r_State)
        IDLE: begin
          r_Cnt <= '0;
          if (i_Valid) begin
            r_Data  <= i_Byte;
            r_Tx    <= 1'b0;
            r_State <= START;
          end
        end
        START: begin
          if (w_BitEnd) begin
            r_Cnt    <= '0;
            r_BitIdx <= '0;
            r_Tx     <= r_Data[0];
            r_State  <= DATA;
          end else begin
            r_Cnt <= r_Cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_BitEnd) begin
            r_Cnt <= '0;
            if (r_BitIdx == 3'd7) begin
`ifdef SCORE_UART_TX_PARITY_EN
              r_Tx    <= ^r_Data;
              r_State <= PARITY;
`else
              r_Tx    <= 1'b1;
              r_State <= STOP;
`endif
            end else begin
              r_BitIdx <= r_BitIdx + 3'd1;
              r_Tx     <= r_Data[r_BitIdx + 3'd1];
            end
          end else begin
            r_Cnt <= r_Cnt + 1'b1;
          end
        end
`ifdef SCORE_UART_TX_PARITY_EN
        PARITY: begin
          if (w_BitEnd) begin
            r_Cnt   <= '0;
            r_Tx    <= 1'b1;
            r_State <= STOP;
          end else begin
            r_Cnt <= r_Cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (w_BitEnd) begin
            r_Cnt <= '0;
            if (i_Valid) begin
              r_Data  <= i_Byte;
              r_Tx    <= 1'b0;
              r_State <= START;
            end else begin
              r_Tx    <= 1'b1;
              r_State <= IDLE;
            end
          end else begin
            r_Cnt <= r_Cnt + 1'b1;
          end
        end
        default: begin
          r_Cnt   <= '0;
          r_Tx    <= 1'b1;
          r_State <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/score_uart_tx.sv
// Sends a 3-byte score frame (header, {P1,P2}, checksum) whenever the scores change.
// Define SCORE_UART_TX_PARITY_EN for 8E1 bytes instead of 8N1.
module score_uart_tx
  import score_uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter logic [7:0] FRAME_HDR    = DEFAULT_FRAME_HDR
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [3:0] i_Score_P1,
  input  logic [3:0] i_Score_P2,
  output logic       o_UART_TX,
  output logic       o_TX_Active,
  output logic       o_Frame_Done
);

  localparam logic [1:0] LAST_IDX = 2'(FRAME_BYTES);

  t_State     r_State;
  logic [3:0] r_Last_P1;
  logic [3:0] r_Last_P2;
  logic [7:0] r_Snap;
  logic [1:0] r_ByteIdx;
  logic       r_FrameDone;
  logic       w_Change;
  logic       w_Valid;
  logic       w_Busy;
  logic       w_SerDone;
  logic       w_Accept;
  logic [7:0] w_Byte;

  assign w_Change = {i_Score_P1, i_Score_P2} != {r_Last_P1, r_Last_P2};
  assign w_Valid  = (r_State == START) && (r_ByteIdx != LAST_IDX);
  assign w_Accept = w_Valid && !w_Busy;

  always_comb begin
    w_Byte = FRAME_HDR;
    case (r_ByteIdx)
      2'd1:    w_Byte = r_Snap;
      2'd2:    w_Byte = FRAME_HDR ^ r_Snap;
      default: w_Byte = FRAME_HDR;
    endcase
  end

  // START here means "frame in flight"; bit-level states live in the serializer.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_State     <= IDLE;
      r_Last_P1   <= '0;
      r_Last_P2   <= '0;
      r_Snap      <= '0;
      r_ByteIdx   <= '0;
      r_FrameDone <= 1'b0;
    end else begin
      r_FrameDone <= 1'b0;
      case (r_State)
        IDLE: begin
          if (w_Change) begin
            r_Last_P1 <= i_Score_P1;
            r_Last_P2 <= i_Score_P2;
            r_Snap    <= {i_Score_P1, i_Score_P2};
            r_ByteIdx <= '0;
            r_State   <= START;
          end
        end
        START: begin
          if (w_Accept) begin
            r_ByteIdx <= r_ByteIdx + 2'd1;
          end
          if ((r_ByteIdx == LAST_IDX) && w_SerDone) begin
            r_FrameDone <= 1'b1;
            r_State     <= DONE;
          end
        end
        default: r_State <= IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_Byte (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Byte  (w_Byte),
    .i_Valid (w_Valid),
    .o_Busy  (w_Busy),
    .o_Done  (w_SerDone),
    .o_Tx    (o_UART_TX),
    .o_Active(o_TX_Active)
  );

  assign o_Frame_Done = r_FrameDone;

endmodule

// File: tb/tb_score_uart_tx.sv
// Scoreboard bench for score_uart_tx: a line monitor decodes bytes and checks them
// against frames queued when scores are driven. Honours SCORE_UART_TX_PARITY_EN.
module tb_score_uart_tx;

  localparam int         CLKS = 4;
  localparam logic [7:0] HDR  = 8'h53;
`ifdef SCORE_UART_TX_PARITY_EN
  localparam int BITS = 11;
`else
  localparam int BITS = 10;
`endif
  localparam int FRAME_CLKS = 3 * BITS * CLKS;

  logic       clk = 1'b0;
  logic       rstL;
  logic [3:0] p1, p2;
  logic       tx, active, done;

  int checkCount  = 0;
  int failCount   = 0;
  int doneCount   = 0;
  int activeCount = 0;
  int lowCount    = 0;
  int rstPulses   = 0;
  logic [7:0] expQ[$];

  always #5 clk = ~clk;

  score_uart_tx #(.CLKS_PER_BIT(CLKS), .FRAME_HDR(HDR)) dut (
    .i_Clk       (clk),
    .i_Rst_L     (rstL),
    .i_Score_P1  (p1),
    .i_Score_P2  (p2),
    .o_UART_TX   (tx),
    .o_TX_Active (active),
    .o_Frame_Done(done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pushFrame(input logic [3:0] a, input logic [3:0] b);
    expQ.push_back(HDR);
    expQ.push_back({a, b});
    expQ.push_back(HDR ^ {a, b});
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input bit expectFrame);
    @(posedge clk);
    #1;
    p1 = a;
    p2 = b;
    if (expectFrame) pushFrame(a, b);
  endtask

  task automatic resetCounters();
    doneCount   = 0;
    activeCount = 0;
    lowCount    = 0;
  endtask

  task automatic waitFrameDone(input int budget);
    int startDone = doneCount;
    int n = 0;
    while (doneCount == startDone && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("frame_done_seen", 32'(doneCount != startDone), 1);
  endtask

  // Decodes one byte whose start bit was seen at the current falling edge.
  task automatic receiveByte();
    logic [BITS-1:0] samp;
    logic [7:0]      data;
    logic [7:0]      expByte;
    int              startRst;
    startRst = rstPulses;
    samp = '0;
    for (int c = 1; c <= CLKS * (BITS - 1) + CLKS / 2; c++) begin
      @(negedge clk);
      if (rstPulses != startRst) return;
      if (c % CLKS == CLKS / 2) samp[c / CLKS] = tx;
    end
    data = samp[8:1];
    checkOutput("start_bit", 32'(samp[0]), 0);
    checkOutput("stop_bit", 32'(samp[BITS-1]), 1);
    if (expQ.size() == 0) begin
      checkOutput("unexpected_byte", 32'(data), 32'h100);
    end else begin
      expByte = expQ.pop_front();
      checkOutput("byte", 32'(data), 32'(expByte));
`ifdef SCORE_UART_TX_PARITY_EN
      checkOutput("parity_bit", 32'(samp[9]), 32'(^expByte));
`endif
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (tx === 1'b0) receiveByte();
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1) doneCount++;
    if (active === 1'b1) activeCount++;
    if (tx !== 1'b1) lowCount++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstL = 1'b0;
    p1   = 4'd0;
    p2   = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_tx", 32'(tx), 1);
    checkOutput("rst_active", 32'(active), 0);
    checkOutput("rst_done", 32'(done), 0);
    rstL = 1'b1;

    // Unchanged 0/0 scores: nothing may be sent.
    resetCounters();
    repeat (1000) @(posedge clk);
    #1;
    checkOutput("idle_line_low", 32'(lowCount), 0);
    checkOutput("idle_done", 32'(doneCount), 0);

    // Single frame for P1=3.
    resetCounters();
    applyStimulus(4'd3, 4'd0, 1'b1);
    waitFrameDone(FRAME_CLKS + 20);
    checkOutput("p1_active_clks", 32'(activeCount), 32'(FRAME_CLKS));
    repeat (20) @(posedge clk);
    #1;
    checkOutput("p1_done_pulses", 32'(doneCount), 1);
    checkOutput("p1_line_high", 32'(tx), 1);
    checkOutput("p1_sb_left", 32'(expQ.size()), 0);

    // Mid-frame changes collapse into one follow-up frame with the latest values.
    resetCounters();
    applyStimulus(4'd3, 4'd1, 1'b1);
    repeat (61) @(posedge clk);
    applyStimulus(4'd3, 4'd5, 1'b0);
    repeat (39) @(posedge clk);
    applyStimulus(4'd3, 4'd7, 1'b1);
    waitFrameDone(2 * FRAME_CLKS);
    waitFrameDone(2 * FRAME_CLKS);
    repeat (300) @(posedge clk);
    #1;
    checkOutput("pend_done_pulses", 32'(doneCount), 2);
    checkOutput("pend_active_clks", 32'(activeCount), 32'(2 * FRAME_CLKS));
    checkOutput("pend_sb_left", 32'(expQ.size()), 0);

    // Back to 0/0, then both scores change on the same edge.
    applyStimulus(4'd0, 4'd0, 1'b1);
    waitFrameDone(FRAME_CLKS + 20);
    repeat (5) @(posedge clk);
    resetCounters();
    applyStimulus(4'd2, 4'd2, 1'b1);
    waitFrameDone(FRAME_CLKS + 20);
    repeat (50) @(posedge clk);
    #1;
    checkOutput("both_done_pulses", 32'(doneCount), 1);
    checkOutput("both_active_clks", 32'(activeCount), 32'(FRAME_CLKS));
    checkOutput("both_sb_left", 32'(expQ.size()), 0);

    // P1=1, P2=0 gives bytes with distinct parity values.
    resetCounters();
    applyStimulus(4'd1, 4'd0, 1'b1);
    waitFrameDone(FRAME_CLKS + 20);
    checkOutput("par_active_clks", 32'(activeCount), 32'(FRAME_CLKS));
    repeat (20) @(posedge clk);
    #1;
    checkOutput("par_sb_left", 32'(expQ.size()), 0);

    // Reset in the middle of data bit 4 of the header byte.
    applyStimulus(4'd5, 4'd9, 1'b1);
    repeat (23) @(posedge clk);
    #1;
    checkOutput("mid_active", 32'(active), 1);
    rstL = 1'b0;
    rstPulses++;
    expQ.delete();
    @(posedge clk);
    #1;
    checkOutput("mid_rst_tx", 32'(tx), 1);
    checkOutput("mid_rst_active", 32'(active), 0);
    checkOutput("mid_rst_done", 32'(done), 0);
    rstL = 1'b1;
    resetCounters();
    pushFrame(4'd5, 4'd9);
    waitFrameDone(FRAME_CLKS + 20);
    repeat (50) @(posedge clk);
    #1;
    checkOutput("rst_fresh_active", 32'(activeCount), 32'(FRAME_CLKS));
    checkOutput("rst_fresh_done", 32'(doneCount), 1);
    checkOutput("rst_fresh_sb_left", 32'(expQ.size()), 0);
    checkOutput("rst_fresh_line", 32'(tx), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
